// File: rtl/des_key_sched.sv
// DES key schedule: PC-1 load, per-round C/D rotation, PC-2 subkey out.
// Emits K1..K16 (encrypt) or K16..K1 (decrypt), one per handshake.
module des_key_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key_in,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  key_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state;
    logic [55:0] cd;
    logic [3:0]  seq;
    logic        mode;
    logic [55:0] cd_ld;
    logic [4:0]  rnd;
    logic        two;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] v);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[47-i] = v[56-PC2[i]];
        return r;
    endfunction

    function automatic logic [27:0] rol(input logic [27:0] h, input logic t);
        return t ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
    endfunction

    function automatic logic [27:0] ror(input logic [27:0] h, input logic t);
        return t ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
    endfunction

    assign cd_ld = pc1(key_in);

    // Round whose shift amount moves us to the next subkey in this direction
    assign rnd = mode ? {1'b0, key_idx} + 5'd1 : {1'b0, key_idx} + 5'd2;
    assign two = !(rnd == 5'd1 || rnd == 5'd2 || rnd == 5'd9 || rnd == 5'd16);

    assign busy         = (state == RUN);
    assign subkey_valid = busy;
    assign subkey       = pc2(cd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cd      <= '0;
            key_idx <= '0;
            seq     <= '0;
            mode    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        // C16D16 equals C0D0, so decrypt starts unrotated
                        cd      <= decrypt ? cd_ld
                                   : {rol(cd_ld[55:28], 1'b0),
                                      rol(cd_ld[27:0], 1'b0)};
                        key_idx <= decrypt ? 4'd15 : 4'd0;
                        seq     <= '0;
                        mode    <= decrypt;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (subkey_ready) begin
                        if (seq == 4'd15) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            seq <= seq + 4'd1;
                            if (mode) begin
                                cd      <= {ror(cd[55:28], two),
                                            ror(cd[27:0], two)};
                                key_idx <= key_idx - 4'd1;
                            end else begin
                                cd      <= {rol(cd[55:28], two),
                                            rol(cd[27:0], two)};
                                key_idx <= key_idx + 4'd1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_key_sched.sv
// Bench for des_key_sched: random handshakes against a cumulative-shift
// reference of the DES key schedule.
module tb_des_key_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        decrypt;
    logic [63:0] key_in;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  key_idx;
    logic        busy;
    logic        done;

    int nvec = 0;
    int nerr = 0;

    logic [47:0] cap [16];
    logic [47:0] enc_cap [16];

    int pc1_t [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    int pc2_t [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    int sh_t [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] K1KEY = 64'h133457799BBCDFF1;

    des_key_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .decrypt      (decrypt),
        .key_in       (key_in),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .key_idx      (key_idx),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Subkey for DES round r: rotate C0/D0 left by the total shift so far
    function automatic logic [47:0] model_key(input logic [63:0] k,
                                              input int r);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] o;
        int tot;
        for (int i = 0; i < 56; i++) cd[55-i] = k[64-pc1_t[i]];
        c = cd[55:28];
        d = cd[27:0];
        tot = 0;
        for (int i = 0; i < r; i++) tot += sh_t[i];
        for (int j = 0; j < tot; j++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-pc2_t[i]];
        return o;
    endfunction

    task automatic do_start(input logic [63:0] k, input bit dec);
        @(negedge clk);
        start   = 1'b1;
        decrypt = dec;
        key_in  = k;
        @(negedge clk);
        start   = 1'b0;
        key_in  = {$urandom, $urandom};
        decrypt = 1'($urandom_range(0, 1));
    endtask

    task automatic consume(input logic [63:0] k, input bit dec,
                           input int pct, input bit spam, input bit b2b,
                           input logic [63:0] nk, output int cycles);
        int got, idx;
        got = 0;
        cycles = 0;
        while (got < 16 && cycles < 2000) begin
            idx = dec ? 15 - got : got;
            check("valid", 64'(subkey_valid), 64'd1);
            check("key_idx", 64'(key_idx), 64'(idx));
            check("subkey", 64'(subkey), 64'(model_key(k, idx + 1)));
            cap[got] = subkey;
            subkey_ready = ($urandom_range(0, 99) < pct);
            if (spam) begin
                start   = 1'($urandom_range(0, 1));
                decrypt = 1'($urandom_range(0, 1));
                key_in  = {$urandom, $urandom};
            end
            if (b2b && got == 15 && subkey_ready) begin
                start   = 1'b1;
                decrypt = 1'b0;
                key_in  = nk;
            end
            @(negedge clk);
            if (subkey_ready) got++;
            cycles++;
        end
        check("accepted", 64'(got), 64'd16);
        subkey_ready = 1'b0;
        if (!b2b) start = 1'b0;
        check("done_hi", 64'(done), 64'd1);
        check("busy_lo", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0;
        check("done_lo", 64'(done), 64'd0);
        check("busy_nxt", 64'(busy), b2b ? 64'd1 : 64'd0);
    endtask

    initial begin
        int cyc;
        logic [63:0] rk;
        rst_n = 1'b0;
        start = 1'b0;
        decrypt = 1'b0;
        key_in = '0;
        subkey_ready = 1'b0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(subkey_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_idx", 64'(key_idx), 64'd0);
        check("rst_subkey", 64'(subkey), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_start(K1KEY, 1'b0);
        consume(K1KEY, 1'b0, 100, 1'b0, 1'b0, 64'd0, cyc);
        check("latency", 64'(cyc), 64'd16);
        check("vec_k1", 64'(cap[0]), 64'h1B02EFFC7072);
        check("vec_k2", 64'(cap[1]), 64'h79AED9DBC9E5);
        check("vec_k16", 64'(cap[15]), 64'hCB3D8B0E17F5);
        for (int i = 0; i < 16; i++) enc_cap[i] = cap[i];

        do_start(K1KEY, 1'b1);
        consume(K1KEY, 1'b1, 100, 1'b0, 1'b0, 64'd0, cyc);
        check("dec_first", 64'(cap[0]), 64'hCB3D8B0E17F5);
        check("dec_last", 64'(cap[15]), 64'h1B02EFFC7072);
        for (int i = 0; i < 16; i++)
            check("dec_rev", 64'(cap[i]), 64'(enc_cap[15-i]));

        do_start(64'h0, 1'b0);
        consume(64'h0, 1'b0, 100, 1'b0, 1'b0, 64'd0, cyc);
        do_start(64'h0101010101010101, 1'b1);
        consume(64'h0101010101010101, 1'b1, 100, 1'b0, 1'b0, 64'd0, cyc);
        check("par_zero", 64'(cap[7]), 64'h0);
        do_start(64'hFEFEFEFEFEFEFEFE, 1'b0);
        consume(64'hFEFEFEFEFEFEFEFE, 1'b0, 100, 1'b0, 1'b0, 64'd0, cyc);
        check("all_ones", 64'(cap[9]), 64'hFFFFFFFFFFFF);

        do_start(K1KEY, 1'b0);
        consume(K1KEY, 1'b0, 50, 1'b1, 1'b0, 64'd0, cyc);
        for (int i = 0; i < 16; i++)
            check("stall_seq", 64'(cap[i]), 64'(enc_cap[i]));

        for (int n = 0; n < 4; n++) begin
            bit d;
            rk = {$urandom, $urandom};
            d  = 1'($urandom_range(0, 1));
            do_start(rk, d);
            consume(rk, d, 70, 1'b1, 1'b0, 64'd0, cyc);
        end

        do_start(K1KEY, 1'b0);
        subkey_ready = 1'b1;
        repeat (7) @(negedge clk);
        subkey_ready = 1'b0;
        check("mid_idx", 64'(key_idx), 64'd7);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_valid", 64'(subkey_valid), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_idx", 64'(key_idx), 64'd0);
        check("arst_subkey", 64'(subkey), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_start(K1KEY, 1'b1);
        consume(K1KEY, 1'b1, 100, 1'b0, 1'b0, 64'd0, cyc);

        rk = {$urandom, $urandom};
        do_start(K1KEY, 1'b0);
        consume(K1KEY, 1'b0, 100, 1'b0, 1'b1, rk, cyc);
        consume(rk, 1'b0, 100, 1'b0, 1'b0, 64'd0, cyc);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
